// File: rtl/rename_unit.sv
// rename_unit: register-rename stage feeding the reorder buffer.
//
// Maps architectural sources/destination onto physical registers using a
// speculative RAT, an architectural (committed) RAT and a circular free list.
// Renamed results are registered (latency 1, single-cycle ren_valid_o pulse).
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   dec_valid_i, dec_rs1/rs2/rd_i     decoded instruction in
//   dec_ready_o                       rename accepts this cycle
//   rob_ready_i                       ROB has a free entry
//   ren_valid_o, ren_ps1/ps2_o        renamed instruction out
//   ren_rd_o, ren_pd_o, ren_old_pd_o  allocation tuple for the ROB
//   commit_valid_i, commit_rd_i,
//   commit_pd_i, commit_old_pd_i      retiring mapping from the ROB
//   branch_mispredict_i               flush un-committed renames
//   free_count_o                      free-list occupancy (0..32)
//   rn_err_o                          sticky protocol error
//
// Optional feature: define RENAME_PROTECT_EN to enable commit protocol checks
// (rn_err_o and suppression of the offending free-list push). Without it,
// rn_err_o is tied low.

module rename_unit #(
    parameter int unsigned ArchRegs = 32,
    parameter int unsigned PhysRegs = 64
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      dec_valid_i,
    input  logic [$clog2(ArchRegs)-1:0]               dec_rs1_i,
    input  logic [$clog2(ArchRegs)-1:0]               dec_rs2_i,
    input  logic [$clog2(ArchRegs)-1:0]               dec_rd_i,
    output logic                                      dec_ready_o,
    input  logic                                      rob_ready_i,
    output logic                                      ren_valid_o,
    output logic [$clog2(PhysRegs)-1:0]               ren_ps1_o,
    output logic [$clog2(PhysRegs)-1:0]               ren_ps2_o,
    output logic [$clog2(ArchRegs)-1:0]               ren_rd_o,
    output logic [$clog2(PhysRegs)-1:0]               ren_pd_o,
    output logic [$clog2(PhysRegs)-1:0]               ren_old_pd_o,
    input  logic                                      commit_valid_i,
    input  logic [$clog2(ArchRegs)-1:0]               commit_rd_i,
    input  logic [$clog2(PhysRegs)-1:0]               commit_pd_i,
    input  logic [$clog2(PhysRegs)-1:0]               commit_old_pd_i,
    input  logic                                      branch_mispredict_i,
    output logic [$clog2(PhysRegs-ArchRegs):0]        free_count_o,
    output logic                                      rn_err_o
);

    localparam int unsigned Aw      = $clog2(ArchRegs);
    localparam int unsigned Pw      = $clog2(PhysRegs);
    localparam int unsigned FlDepth = PhysRegs - ArchRegs;
    localparam int unsigned FlAw    = $clog2(FlDepth);
    localparam int unsigned PtrW    = FlAw + 1;  // extra wrap bit distinguishes full/empty

    logic [Pw-1:0]   spec_rat_q [ArchRegs];
    logic [Pw-1:0]   spec_rat_d [ArchRegs];
    logic [Pw-1:0]   arch_rat_q [ArchRegs];
    logic [Pw-1:0]   arch_rat_d [ArchRegs];
    logic [Pw-1:0]   fl_q       [FlDepth];
    logic [Pw-1:0]   fl_d       [FlDepth];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [PtrW-1:0] commit_head_q, commit_head_d;

    logic            ren_valid_q, ren_valid_d;
    logic [Pw-1:0]   ren_ps1_q, ren_ps1_d;
    logic [Pw-1:0]   ren_ps2_q, ren_ps2_d;
    logic [Aw-1:0]   ren_rd_q, ren_rd_d;
    logic [Pw-1:0]   ren_pd_q, ren_pd_d;
    logic [Pw-1:0]   ren_old_pd_q, ren_old_pd_d;

    logic            fire;
    logic            alloc;
    logic            push;
    logic [Pw-1:0]   fl_head;

    assign free_count_o = tail_q - head_q;
    assign dec_ready_o  = rob_ready_i & (free_count_o != '0) & ~branch_mispredict_i;
    assign fire         = dec_valid_i & dec_ready_o;
    assign alloc        = fire & (dec_rd_i != '0);
    assign fl_head      = fl_q[head_q[FlAw-1:0]];

`ifdef RENAME_PROTECT_EN
    logic bad_commit;
    logic rn_err_q;

    assign bad_commit = commit_valid_i &
                        ((free_count_o == PtrW'(FlDepth)) ||
                         ((commit_old_pd_i == '0) && (commit_rd_i != '0)) ||
                         (commit_rd_i == '0));
    // A bad commit does not return a register, so neither tail nor
    // commit_head move; this keeps tail - commit_head within the list depth.
    assign push       = commit_valid_i & ~bad_commit;
    assign rn_err_o   = rn_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rn_err_q <= 1'b0;
        end else if (bad_commit) begin
            rn_err_q <= 1'b1;
        end
    end
`else
    assign push     = commit_valid_i;
    assign rn_err_o = 1'b0;
`endif

    // Commit side: architectural RAT and free-list return.
    always_comb begin
        arch_rat_d    = arch_rat_q;
        fl_d          = fl_q;
        tail_d        = tail_q;
        commit_head_d = commit_head_q;
        if (commit_valid_i) begin
            arch_rat_d[commit_rd_i] = commit_pd_i;
        end
        if (push) begin
            fl_d[tail_q[FlAw-1:0]] = commit_old_pd_i;
            tail_d                 = tail_q + PtrW'(1);
            commit_head_d          = commit_head_q + PtrW'(1);
        end
    end

    // Speculative side: allocation, or restore from the post-commit state.
    always_comb begin
        spec_rat_d = spec_rat_q;
        head_d     = head_q;
        if (branch_mispredict_i) begin
            spec_rat_d = arch_rat_d;
            head_d     = commit_head_d;
        end else if (alloc) begin
            spec_rat_d[dec_rd_i] = fl_head;
            head_d               = head_q + PtrW'(1);
        end
    end

    // Registered rename results; fields only reload on fire.
    always_comb begin
        ren_valid_d  = fire;
        ren_ps1_d    = ren_ps1_q;
        ren_ps2_d    = ren_ps2_q;
        ren_rd_d     = ren_rd_q;
        ren_pd_d     = ren_pd_q;
        ren_old_pd_d = ren_old_pd_q;
        if (fire) begin
            ren_ps1_d    = (dec_rs1_i == '0) ? '0 : spec_rat_q[dec_rs1_i];
            ren_ps2_d    = (dec_rs2_i == '0) ? '0 : spec_rat_q[dec_rs2_i];
            ren_rd_d     = dec_rd_i;
            ren_pd_d     = alloc ? fl_head : '0;
            ren_old_pd_d = alloc ? spec_rat_q[dec_rd_i] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ArchRegs; i++) begin
                spec_rat_q[i] <= Pw'(i);
                arch_rat_q[i] <= Pw'(i);
            end
            for (int k = 0; k < FlDepth; k++) begin
                fl_q[k] <= Pw'(ArchRegs + k);
            end
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= PtrW'(FlDepth);
            ren_valid_q   <= 1'b0;
            ren_ps1_q     <= '0;
            ren_ps2_q     <= '0;
            ren_rd_q      <= '0;
            ren_pd_q      <= '0;
            ren_old_pd_q  <= '0;
        end else begin
            spec_rat_q    <= spec_rat_d;
            arch_rat_q    <= arch_rat_d;
            fl_q          <= fl_d;
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            ren_valid_q   <= ren_valid_d;
            ren_ps1_q     <= ren_ps1_d;
            ren_ps2_q     <= ren_ps2_d;
            ren_rd_q      <= ren_rd_d;
            ren_pd_q      <= ren_pd_d;
            ren_old_pd_q  <= ren_old_pd_d;
        end
    end

    assign ren_valid_o  = ren_valid_q;
    assign ren_ps1_o    = ren_ps1_q;
    assign ren_ps2_o    = ren_ps2_q;
    assign ren_rd_o     = ren_rd_q;
    assign ren_pd_o     = ren_pd_q;
    assign ren_old_pd_o = ren_old_pd_q;

endmodule

// File: tb/tb_rename_unit.sv
// Scoreboard bench for rename_unit: stimulus pushes expected rename tuples,
// a monitor pops and compares whenever ren_valid_o is high.
module tb_rename_unit;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       dec_valid_i;
    logic [4:0] dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic       dec_ready_o;
    logic       rob_ready_i;
    logic       ren_valid_o;
    logic [5:0] ren_ps1_o, ren_ps2_o, ren_pd_o, ren_old_pd_o;
    logic [4:0] ren_rd_o;
    logic       commit_valid_i;
    logic [4:0] commit_rd_i;
    logic [5:0] commit_pd_i, commit_old_pd_i;
    logic       branch_mispredict_i;
    logic [5:0] free_count_o;
    logic       rn_err_o;

    rename_unit dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .dec_valid_i        (dec_valid_i),
        .dec_rs1_i          (dec_rs1_i),
        .dec_rs2_i          (dec_rs2_i),
        .dec_rd_i           (dec_rd_i),
        .dec_ready_o        (dec_ready_o),
        .rob_ready_i        (rob_ready_i),
        .ren_valid_o        (ren_valid_o),
        .ren_ps1_o          (ren_ps1_o),
        .ren_ps2_o          (ren_ps2_o),
        .ren_rd_o           (ren_rd_o),
        .ren_pd_o           (ren_pd_o),
        .ren_old_pd_o       (ren_old_pd_o),
        .commit_valid_i     (commit_valid_i),
        .commit_rd_i        (commit_rd_i),
        .commit_pd_i        (commit_pd_i),
        .commit_old_pd_i    (commit_old_pd_i),
        .branch_mispredict_i(branch_mispredict_i),
        .free_count_o       (free_count_o),
        .rn_err_o           (rn_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [5:0] ps1;
        logic [5:0] ps2;
        logic [4:0] rd;
        logic [5:0] pd;
        logic [5:0] old_pd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk_i) begin
        if (rst_ni && ren_valid_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ren_valid: got 1 expected 0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ren_ps1", int'(ren_ps1_o), int'(e.ps1));
                check("ren_ps2", int'(ren_ps2_o), int'(e.ps2));
                check("ren_rd", int'(ren_rd_o), int'(e.rd));
                check("ren_pd", int'(ren_pd_o), int'(e.pd));
                check("ren_old_pd", int'(ren_old_pd_o), int'(e.old_pd));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("rst_ren_valid", int'(ren_valid_o), 0);
        check("rst_ren_pd", int'(ren_pd_o), 0);
        check("rst_free_count", int'(free_count_o), 32);
        check("rst_rn_err", int'(rn_err_o), 0);
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // Drive one instruction for one edge; expected tuple queued for the monitor.
    task automatic rename(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [5:0] eps1, input logic [5:0] eps2,
                          input logic [5:0] epd, input logic [5:0] eold);
        exp_t e;
        dec_valid_i = 1'b1;
        dec_rs1_i   = rs1;
        dec_rs2_i   = rs2;
        dec_rd_i    = rd;
        e = '{ps1: eps1, ps2: eps2, rd: rd, pd: epd, old_pd: eold};
        exp_q.push_back(e);
        tick();
        dec_valid_i = 1'b0;
    endtask

    task automatic set_commit(input logic v, input logic [4:0] rd, input logic [5:0] pd,
                              input logic [5:0] old);
        commit_valid_i  = v;
        commit_rd_i     = rd;
        commit_pd_i     = pd;
        commit_old_pd_i = old;
    endtask

    initial begin
        rst_ni              = 1'b0;
        dec_valid_i         = 1'b0;
        dec_rs1_i           = '0;
        dec_rs2_i           = '0;
        dec_rd_i            = '0;
        rob_ready_i         = 1'b1;
        branch_mispredict_i = 1'b0;
        set_commit(1'b0, 5'd0, 6'd0, 6'd0);

        // Reset release and first rename.
        do_reset();
        check("init_free_count", int'(free_count_o), 32);
        check("init_dec_ready", int'(dec_ready_o), 1);
        rename(5'd1, 5'd0, 5'd1, 6'd1, 6'd0, 6'd32, 6'd1);
        // Back-to-back: rd=2 then rs1=2, rd=2 sees the first write.
        rename(5'd0, 5'd0, 5'd2, 6'd0, 6'd0, 6'd33, 6'd2);
        rename(5'd2, 5'd1, 5'd2, 6'd33, 6'd32, 6'd34, 6'd33);
        check("b2b_free_count", int'(free_count_o), 29);

        // Exhaust the free list, then one commit frees p1.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            logic [4:0] rd;
            rd = 5'((i % 31) + 1);
            rename(5'd0, 5'd0, rd, 6'd0, 6'd0, 6'(32 + i), (i == 31) ? 6'd32 : 6'(rd));
        end
        check("full_free_count", int'(free_count_o), 0);
        check("full_dec_ready", int'(dec_ready_o), 0);
        set_commit(1'b1, 5'd1, 6'd32, 6'd1);
        check("commit_same_cycle_ready", int'(dec_ready_o), 0);
        tick();
        set_commit(1'b0, 5'd0, 6'd0, 6'd0);
        check("after_commit_ready", int'(dec_ready_o), 1);
        check("after_commit_free", int'(free_count_o), 1);
        rename(5'd1, 5'd0, 5'd7, 6'd63, 6'd0, 6'd1, 6'd38);

        // Mispredict restore.
        do_reset();
        rename(5'd0, 5'd0, 5'd1, 6'd0, 6'd0, 6'd32, 6'd1);
        rename(5'd0, 5'd0, 5'd2, 6'd0, 6'd0, 6'd33, 6'd2);
        rename(5'd0, 5'd0, 5'd3, 6'd0, 6'd0, 6'd34, 6'd3);
        set_commit(1'b1, 5'd1, 6'd32, 6'd1);
        tick();
        set_commit(1'b0, 5'd0, 6'd0, 6'd0);
        branch_mispredict_i = 1'b1;
        dec_valid_i = 1'b1;
        #1;
        check("mispredict_dec_ready", int'(dec_ready_o), 0);
        tick();
        dec_valid_i = 1'b0;
        branch_mispredict_i = 1'b0;
        check("mispredict_free_count", int'(free_count_o), 32);
        rename(5'd2, 5'd1, 5'd5, 6'd2, 6'd32, 6'd33, 6'd5);

        // Backpressure, rd=0, commit+fire same cycle.
        do_reset();
        rob_ready_i = 1'b0;
        dec_valid_i = 1'b1;
        dec_rs1_i   = 5'd3;
        dec_rd_i    = 5'd3;
        #1;
        check("stall_dec_ready", int'(dec_ready_o), 0);
        tick();
        dec_valid_i = 1'b0;
        rob_ready_i = 1'b1;
        tick();
        check("stall_free_count", int'(free_count_o), 32);
        rename(5'd3, 5'd0, 5'd0, 6'd3, 6'd0, 6'd0, 6'd0);
        check("rd0_free_count", int'(free_count_o), 32);
        rename(5'd3, 5'd0, 5'd3, 6'd3, 6'd0, 6'd32, 6'd3);
        check("alloc_free_count", int'(free_count_o), 31);
        set_commit(1'b1, 5'd3, 6'd32, 6'd3);
        rename(5'd3, 5'd0, 5'd4, 6'd32, 6'd0, 6'd33, 6'd4);
        set_commit(1'b0, 5'd0, 6'd0, 6'd0);
        check("commit_fire_free_count", int'(free_count_o), 31);

        // Protocol error on commit while the free list is full.
        do_reset();
`ifdef RENAME_PROTECT_EN
        set_commit(1'b1, 5'd1, 6'd5, 6'd9);
        tick();
        set_commit(1'b0, 5'd0, 6'd0, 6'd0);
        check("err_set", int'(rn_err_o), 1);
        check("err_free_count", int'(free_count_o), 32);
        tick();
        tick();
        check("err_sticky", int'(rn_err_o), 1);
`else
        tick();
        check("err_tied_low", int'(rn_err_o), 0);
`endif

        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
